// File: rtl/color_sequence_checker.sv
// rtl/color_sequence_checker.sv - five-slot color pattern guessing checker
// Judges guesses against a latched pattern, with miss limit and idle timeout.
module color_sequence_checker #(
    parameter int MAX_MISSES     = 3,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [14:0] pattern_in,
    input  logic        guess_valid,
    input  logic [2:0]  guess_color,
    output logic        guess_ready,
    output logic        result_valid,
    output logic        result_hit,
    output logic        result_timeout,
    output logic [2:0]  slot_idx,
    output logic [2:0]  expected_color,
    output logic [7:0]  score,
    output logic [3:0]  misses,
    output logic        busy,
    output logic        round_win,
    output logic        round_lose
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, PLAY, DONE} state_t;

    state_t        state_q, state_d;
    logic [14:0]   pattern_q, pattern_d;
    logic [2:0]    slot_q, slot_d;
    logic [3:0]    misses_q, misses_d;
    logic [7:0]    score_q, score_d;
    logic [CW-1:0] tcnt_q, tcnt_d;
    logic          res_valid_q, res_hit_q, res_to_q, win_q, lose_q;

    logic [2:0] slot_code;
    logic       accept, is_hit, timeout_fire, miss_evt, win_evt, lose_evt;
    logic [3:0] misses_inc;

    always_comb begin
        slot_code = 3'b000;
        case (slot_q)
            3'd0:    slot_code = pattern_q[2:0];
            3'd1:    slot_code = pattern_q[5:3];
            3'd2:    slot_code = pattern_q[8:6];
            3'd3:    slot_code = pattern_q[11:9];
            3'd4:    slot_code = pattern_q[14:12];
            default: slot_code = 3'b000;
        endcase
    end

    // Codes 000 and 111 are not real colors, so a slot holding one can never be hit.
    assign accept       = guess_valid && guess_ready;
    assign is_hit       = accept && (guess_color == slot_code)
                          && (slot_code != 3'b000) && (slot_code != 3'b111);
    assign timeout_fire = (TIMEOUT_CYCLES != 0) && (state_q == PLAY) && !start && !accept
                          && (tcnt_q == CW'(TIMEOUT_CYCLES - 1));
    assign miss_evt     = (accept && !is_hit) || timeout_fire;
    assign misses_inc   = misses_q + 4'd1;
    assign win_evt      = is_hit && (slot_q == 3'd4);
    assign lose_evt     = miss_evt && (misses_inc == 4'(MAX_MISSES));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start) state_d = PLAY;
            PLAY:       if (!start && (win_evt || lose_evt)) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        busy           = (state_q == PLAY);
        guess_ready    = busy && !start;
        expected_color = busy ? slot_code : 3'b000;
    end

    always_comb begin
        pattern_d = pattern_q;
        slot_d    = slot_q;
        misses_d  = misses_q;
        score_d   = score_q;
        tcnt_d    = tcnt_q;
        if (start) begin
            pattern_d = pattern_in;
            slot_d    = 3'd0;
            misses_d  = 4'd0;
            tcnt_d    = '0;
        end else if (state_q == PLAY) begin
            tcnt_d = (accept || timeout_fire) ? '0 : tcnt_q + CW'(1);
            if (is_hit) begin
                if (score_q != 8'hFF) score_d = score_q + 8'd1;
                if (slot_q != 3'd4)   slot_d  = slot_q + 3'd1;
            end
            if (miss_evt) misses_d = misses_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pattern_q   <= '0;
            slot_q      <= '0;
            misses_q    <= '0;
            score_q     <= '0;
            tcnt_q      <= '0;
            res_valid_q <= 1'b0;
            res_hit_q   <= 1'b0;
            res_to_q    <= 1'b0;
            win_q       <= 1'b0;
            lose_q      <= 1'b0;
        end else begin
            pattern_q   <= pattern_d;
            slot_q      <= slot_d;
            misses_q    <= misses_d;
            score_q     <= score_d;
            tcnt_q      <= tcnt_d;
            res_valid_q <= accept || timeout_fire;
            res_hit_q   <= is_hit;
            res_to_q    <= timeout_fire;
            win_q       <= win_evt;
            lose_q      <= lose_evt;
        end
    end

    assign result_valid   = res_valid_q;
    assign result_hit     = res_hit_q;
    assign result_timeout = res_to_q;
    assign round_win      = win_q;
    assign round_lose     = lose_q;
    assign slot_idx       = slot_q;
    assign misses         = misses_q;
    assign score          = score_q;

endmodule
